// File: rtl/dsp_add_pipe.sv
// Pipelined signed adder y = a + b mapped onto one DSP48E2-style slice (A:B + C),
// with valid/ready flow control and signed-overflow reporting at the configured width.

// Behavioural subset of a DSP48E2: single-stage A2/B2/C input registers, P register,
// X/Y/Z/W multiplexers and the add/subtract ALU modes. Registers are synchronous, no async reset.
module dsp_add_pipe_slice (
  input  logic        clock,
  input  logic [29:0] a_in,
  input  logic [17:0] b_in,
  input  logic [47:0] c_in,
  input  logic [47:0] pcin,
  input  logic [8:0]  opmode,
  input  logic [3:0]  alumode,
  input  logic        carryin,
  input  logic        cea2,
  input  logic        ceb2,
  input  logic        cec,
  input  logic        cep,
  input  logic        rsta,
  input  logic        rstb,
  input  logic        rstc,
  input  logic        rstp,
  output logic [47:0] p
);

  logic [29:0] a_q, a_d;
  logic [17:0] b_q, b_d;
  logic [47:0] c_q, c_d;
  logic [47:0] p_q, p_d;
  logic [47:0] x_mux, y_mux, z_mux, w_mux, cin, alu;

  always_comb begin
    a_d = a_q;
    if (rsta)      a_d = '0;
    else if (cea2) a_d = a_in;

    b_d = b_q;
    if (rstb)      b_d = '0;
    else if (ceb2) b_d = b_in;

    c_d = c_q;
    if (rstc)     c_d = '0;
    else if (cec) c_d = c_in;

    // no multiplier in this configuration, so the M selections contribute zero
    case (opmode[1:0])
      2'b10:   x_mux = p_q;
      2'b11:   x_mux = {a_q, b_q};
      default: x_mux = '0;
    endcase

    case (opmode[3:2])
      2'b10:   y_mux = '1;
      2'b11:   y_mux = c_q;
      default: y_mux = '0;
    endcase

    case (opmode[6:4])
      3'b001:  z_mux = pcin;
      3'b010:  z_mux = p_q;
      3'b011:  z_mux = c_q;
      3'b100:  z_mux = p_q;
      3'b101:  z_mux = {{17{pcin[47]}}, pcin[47:17]};
      3'b110:  z_mux = {{17{p_q[47]}}, p_q[47:17]};
      default: z_mux = '0;
    endcase

    case (opmode[8:7])
      2'b01:   w_mux = p_q;
      2'b11:   w_mux = c_q;
      default: w_mux = '0;
    endcase

    cin = {47'd0, carryin};

    case (alumode)
      4'b0011: alu = z_mux - (w_mux + x_mux + y_mux + cin);
      default: alu = z_mux + w_mux + x_mux + y_mux + cin;
    endcase

    p_d = p_q;
    if (rstp)     p_d = '0;
    else if (cep) p_d = alu;
  end

  always_ff @(posedge clock) begin
    a_q <= a_d;
    b_q <= b_d;
    c_q <= c_d;
    p_q <= p_d;
  end

  assign p = p_q;

endmodule

module dsp_add_pipe #(
  parameter int width = 48
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [width-1:0] a,
  input  logic signed [width-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [width-1:0]        y,
  output logic                    overflow
);

  if (width < 1 || width > 48) begin : g_width_chk
    $error("[dsp_add_pipe] width:%d configuration not supported", width);
  end

  logic signed [47:0] a_ext, b_ext;
  logic [47:0]        p;
  logic               ce, ce_in, ce_p;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic               same1_q, same1_d, sgn1_q, sgn1_d;
  logic               same2_q, same2_d, sgn2_q, sgn2_d;

  assign a_ext = 48'(a);
  assign b_ext = 48'(b);

  // one enable stalls the whole pipe; DSP registers simply hold when it is low
  always_comb begin
    ce    = out_ready | ~v2_q;
    ce_in = ce & in_valid;
    ce_p  = ce & v1_q;

    v1_d    = v1_q;
    v2_d    = v2_q;
    same1_d = same1_q;
    sgn1_d  = sgn1_q;
    same2_d = same2_q;
    sgn2_d  = sgn2_q;

    if (ce) begin
      v1_d = in_valid;
      v2_d = v1_q;
    end
    if (ce_in) begin
      same1_d = (a[width-1] == b[width-1]);
      sgn1_d  = a[width-1];
    end
    if (ce_p) begin
      same2_d = same1_q;
      sgn2_d  = sgn1_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      same1_q <= 1'b0;
      sgn1_q  <= 1'b0;
      same2_q <= 1'b0;
      sgn2_q  <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      same1_q <= same1_d;
      sgn1_q  <= sgn1_d;
      same2_q <= same2_d;
      sgn2_q  <= sgn2_d;
    end
  end

  dsp_add_pipe_slice u_dsp (
    .clock   (clock),
    .a_in    (b_ext[47:18]),
    .b_in    (b_ext[17:0]),
    .c_in    (a_ext),
    .pcin    (48'd0),
    .opmode  (9'b000110011),
    .alumode (4'b0000),
    .carryin (1'b0),
    .cea2    (ce_in),
    .ceb2    (ce_in),
    .cec     (ce_in),
    .cep     (ce_p),
    .rsta    (1'b0),
    .rstb    (1'b0),
    .rstc    (1'b0),
    .rstp    (1'b0),
    .p       (p)
  );

  // overflow: operands shared a sign and the truncated sum's sign differs from it
  assign in_ready  = ce;
  assign out_valid = v2_q;
  assign y         = v2_q ? p[width-1:0] : '0;
  assign overflow  = v2_q & same2_q & (p[width-1] != sgn2_q);

endmodule

// File: tb/tb_dsp_add_pipe.sv
// Scoreboard bench for dsp_add_pipe at widths 48, 16 and 8: stimulus pushes model
// results on accept, one monitor pops and compares whenever an output is presented.
module tb_dsp_add_pipe;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]        in_valid;
  logic [2:0]        out_ready;
  logic [2:0][47:0]  a_s, b_s;
  logic [2:0]        in_ready_w, out_valid_w, ovf_w;
  logic [2:0][47:0]  y_w;
  logic [47:0]       y48;
  logic [15:0]       y16;
  logic [7:0]        y8;
  logic              ir48, ir16, ir8, ov48, ov16, ov8, of48, of16, of8;

  longint a_v [3];
  longint b_v [3];
  bit [2:0] lat_chk;
  int cyc = 0;
  bit done = 0;
  int to_cnt = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [47:0] y;
    logic        ovf;
    int          acc;
    bit          lat;
  } item_t;

  item_t sbq [3][$];
  bit [2:0] head_seen;
  bit [2:0] prev_stall;
  logic [2:0][47:0] prev_y;
  logic [2:0] prev_ovf;

  dsp_add_pipe #(.width(48)) u_w48 (
    .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(ir48),
    .a(a_s[0]), .b(b_s[0]), .out_valid(ov48), .out_ready(out_ready[0]),
    .y(y48), .overflow(of48));

  dsp_add_pipe #(.width(16)) u_w16 (
    .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(ir16),
    .a(a_s[1][15:0]), .b(b_s[1][15:0]), .out_valid(ov16), .out_ready(out_ready[1]),
    .y(y16), .overflow(of16));

  dsp_add_pipe #(.width(8)) u_w8 (
    .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(ir8),
    .a(a_s[2][7:0]), .b(b_s[2][7:0]), .out_valid(ov8), .out_ready(out_ready[2]),
    .y(y8), .overflow(of8));

  assign in_ready_w  = {ir8, ir16, ir48};
  assign out_valid_w = {ov8, ov16, ov48};
  assign ovf_w       = {of8, of16, of48};
  assign y_w[0]      = y48;
  assign y_w[1]      = {32'd0, y16};
  assign y_w[2]      = {40'd0, y8};

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int wid(input int k);
    return (k == 0) ? 48 : (k == 1) ? 16 : 8;
  endfunction

  // reference: exact integer sum, wrapped to w bits; overflow when outside signed range
  function automatic item_t model(input int w, input longint a, input longint b);
    item_t  it;
    longint one  = 1;
    longint s    = a + b;
    longint hi   = (one <<< (w - 1)) - 1;
    longint lo   = -(one <<< (w - 1));
    longint mask = (one <<< w) - 1;
    it.y   = 48'(s & mask);
    it.ovf = (s > hi) || (s < lo);
    it.acc = 0;
    it.lat = 1'b0;
    return it;
  endfunction

  function automatic longint rnd(input int w);
    longint r;
    longint one = 1;
    case ($urandom_range(0, 5))
      0:       r = (one <<< (w - 1)) - 1;
      1:       r = -(one <<< (w - 1));
      2:       r = -1;
      default: begin
        r = longint'({$urandom(), $urandom()});
        r = r <<< (64 - w);
        r = r >>> (64 - w);
      end
    endcase
    return r;
  endfunction

  task automatic chk(input int k, input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s (width %0d) actual=%0h required=%0h at cycle %0d", name, wid(k), act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int k, input int n);
    in_valid[k] = 1'b0;
    wait_cyc(n);
  endtask

  task automatic send(input int k, input longint a, input longint b);
    bit acc = 1'b0;
    a_v[k] = a;
    b_v[k] = b;
    a_s[k] = 48'(a);
    b_s[k] = 48'(b);
    in_valid[k] = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clock);
      acc = in_ready_w[k];
      @(posedge clock);
      #1;
    end
    if (!acc) to_cnt++;
  endtask

  task automatic rand_phase(input int k, input int n);
    bit rdone = 1'b0;
    lat_chk[k] = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(1, 2));
          send(k, rnd(wid(k)), rnd(wid(k)));
        end
        in_valid[k] = 1'b0;
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clock);
          #1;
          out_ready[k] = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready[k] = 1'b1;
    wait_cyc(8);
  endtask

  // stimulus
  initial begin
    in_valid  = '0;
    out_ready = '1;
    a_s       = '0;
    b_s       = '0;
    lat_chk   = '1;
    for (int k = 0; k < 3; k++) begin
      a_v[k] = 0;
      b_v[k] = 0;
    end

    in_valid[0] = 1'b1;
    a_s[0] = 48'd9;
    b_s[0] = 48'd9;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    send(0, 10, 20);
    idle(0, 4);

    send(0, 5, 3);
    send(0, -7, 2);
    send(0, longint'(48'h7FFF_FFFF_FFFF), 1);
    idle(0, 5);

    lat_chk[1]   = 1'b0;
    out_ready[1] = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(1, i, 100 * i);
        in_valid[1] = 1'b0;
      end
      begin
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
          @(negedge clock);
          seen = out_valid_w[1];
        end
        if (!seen) to_cnt++;
        wait_cyc(5);
        out_ready[1] = 1'b1;
      end
    join
    wait_cyc(8);

    lat_chk[0] = 1'b1;
    send(0, 1, 1);
    idle(0, 1);
    send(0, 2, 2);
    idle(0, 5);

    lat_chk[2] = 1'b1;
    send(2, -128, -1);
    send(2, -1, 1);
    send(2, 127, 1);
    idle(2, 5);

    rand_phase(0, 40);
    rand_phase(1, 40);
    rand_phase(2, 40);

    lat_chk[0] = 1'b1;
    send(0, 100, 1);
    send(0, 200, 2);
    reset = 1'b0;
    in_valid[0] = 1'b0;
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(6);

    done = 1'b1;
  end

  // monitor and scoreboard
  initial begin
    item_t hd;
    item_t it;
    logic  ov, ordy;
    forever begin
      @(negedge clock or negedge reset);
      if (!reset) #1;
      if (done) break;
      for (int k = 0; k < 3; k++) begin
        ov   = out_valid_w[k];
        ordy = out_ready[k];
        if (!reset) begin
          chk(k, ov == 1'b0, "reset_out_valid", longint'(ov), 0);
          chk(k, y_w[k] == 48'd0, "reset_y", longint'(y_w[k]), 0);
          chk(k, ovf_w[k] == 1'b0, "reset_overflow", longint'(ovf_w[k]), 0);
          chk(k, in_ready_w[k] == 1'b1, "reset_in_ready", longint'(in_ready_w[k]), 1);
          sbq[k].delete();
          head_seen[k]  = 1'b0;
          prev_stall[k] = 1'b0;
        end else begin
          chk(k, in_ready_w[k] == (ordy | ~ov), "in_ready", longint'(in_ready_w[k]), longint'(ordy | ~ov));
          if (prev_stall[k]) begin
            chk(k, ov == 1'b1, "hold_out_valid", longint'(ov), 1);
            chk(k, y_w[k] == prev_y[k], "hold_y", longint'(y_w[k]), longint'(prev_y[k]));
            chk(k, ovf_w[k] == prev_ovf[k], "hold_overflow", longint'(ovf_w[k]), longint'(prev_ovf[k]));
          end
          if (ov) begin
            chk(k, sbq[k].size() != 0, "spurious_output", longint'(y_w[k]), 0);
            if (sbq[k].size() != 0) begin
              hd = sbq[k][0];
              if (!head_seen[k]) begin
                head_seen[k] = 1'b1;
                if (hd.lat) chk(k, (cyc - hd.acc) == 2, "latency", cyc - hd.acc, 2);
              end
              chk(k, y_w[k] == hd.y, "y", longint'(y_w[k]), longint'(hd.y));
              chk(k, ovf_w[k] == hd.ovf, "overflow", longint'(ovf_w[k]), longint'(hd.ovf));
              if (ordy) begin
                void'(sbq[k].pop_front());
                head_seen[k] = 1'b0;
              end
            end
          end else begin
            chk(k, (y_w[k] == 48'd0) && (ovf_w[k] == 1'b0), "idle_gating",
                longint'({ovf_w[k], y_w[k]}), 0);
          end
          if (in_valid[k] && in_ready_w[k]) begin
            it     = model(wid(k), a_v[k], b_v[k]);
            it.acc = cyc;
            it.lat = lat_chk[k];
            sbq[k].push_back(it);
          end
          prev_stall[k] = ov & ~ordy;
          prev_y[k]     = y_w[k];
          prev_ovf[k]   = ovf_w[k];
        end
      end
    end
    chk(0, to_cnt == 0, "handshake_timeout", to_cnt, 0);
    for (int k = 0; k < 3; k++)
      chk(k, sbq[k].size() == 0, "results_outstanding", sbq[k].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d, required completion earlier", cyc);
    $fatal(1, "watchdog");
  end

endmodule
